// File: rtl/dff_link_pkg.sv
// Shared definitions for the parametrised DFF link shift chain.
//   clog2      : constant ceiling-log2, used for derived port widths
//   tap_width  : width of the tap selector (never below 1 bit)
//   cnt_width  : width of the occupancy counter (must represent 0..DEPTH)
//   RESET_BIT  : value every stage bit takes on reset or flush
package dff_link_pkg;

  localparam bit RESET_BIT = 1'b0;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // A single-stage chain still needs a 1-bit selector port.
  function automatic int tap_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_link_stage.sv
// One stage of the link: a WIDTH+1 bit register holding {valid, data}.
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset (clears the stage)
//   CLR        synchronous flush (clears the stage, below RST in priority)
//   EN         load enable; stage holds when low
//   stage_in   next {valid, data} to capture
//   stage_out  current {valid, data}
module dff_link_stage
  import dff_link_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH:0]   stage_in,
  output logic [WIDTH:0]   stage_out
);

  logic [WIDTH:0] stage_d;
  logic [WIDTH:0] stage_q;

  always_comb begin
    stage_d = stage_q;
    if (CLR) begin
      stage_d = {(WIDTH + 1){RESET_BIT}};
    end else if (EN) begin
      stage_d = stage_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_q <= {(WIDTH + 1){RESET_BIT}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_out = stage_q;

endmodule

// File: rtl/dff_link_n_shift.sv
// Configurable WIDTH-bit, DEPTH-stage delay line with a valid bit per stage.
// Supports shift enable, synchronous flush, rotate mode, a tap output and
// an occupancy count.
// Ports:
//   CLK, RST       clock and synchronous active-high reset
//   EN             shift enable (chain holds when low)
//   CLR            synchronous flush of all stages and the count
//   ROT            0 = linear shift, 1 = rotate last stage into stage 0
//   input_valid    valid bit captured into stage 0 with input_data
//   input_data     data captured into stage 0
//   tap_sel        stage index observed on tap_data
//   output_valid   valid bit of the last stage
//   output_data    data of the last stage
//   tap_data       data of stage[tap_sel], zero if tap_sel >= DEPTH
//   fill_count     number of stages holding a valid word
//   full           fill_count == DEPTH
module dff_link_n_shift
  import dff_link_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int TAP_W = tap_width(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             ROT,
  input  logic             input_valid,
  input  logic [WIDTH-1:0] input_data,
  input  logic [TAP_W-1:0] tap_sel,
  output logic             output_valid,
  output logic [WIDTH-1:0] output_data,
  output logic [WIDTH-1:0] tap_data,
  output logic [CNT_W-1:0] fill_count,
  output logic             full
);

  // chain[i] is the registered {valid, data} of stage i.
  logic [WIDTH:0] chain     [DEPTH];
  logic [WIDTH:0] chain_nxt [DEPTH];

  logic             last_valid;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      // In rotate mode the tail recirculates and the input port is ignored.
      assign chain_nxt[0] = ROT ? chain[DEPTH-1] : {input_valid, input_data};
    end else begin : g_body
      assign chain_nxt[i] = chain[i-1];
    end

    dff_link_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .CLK       (CLK),
      .RST       (RST),
      .CLR       (CLR),
      .EN        (EN),
      .stage_in  (chain_nxt[i]),
      .stage_out (chain[i])
    );
  end

  assign last_valid   = chain[DEPTH-1][WIDTH];
  assign output_valid = last_valid;
  assign output_data  = chain[DEPTH-1][WIDTH-1:0];

  // Only a linear shift changes occupancy: one word may enter and one leave.
  // The count cannot leave 0..DEPTH because it tracks the stage valid bits;
  // any transient wrap in the modular add/subtract cancels out.
  always_comb begin
    count_d = count_q;
    if (CLR) begin
      count_d = '0;
    end else if (EN && !ROT) begin
      count_d = count_q + CNT_W'(input_valid) - CNT_W'(last_valid);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fill_count = count_q;
  assign full       = (count_q == CNT_W'(DEPTH));

  // Unmatched selector values (possible when DEPTH is not a power of two)
  // fall through to zero.
  always_comb begin
    tap_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_W'(i)) begin
        tap_data = chain[i][WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_dff_link_n_shift.sv
module tb_dff_link_n_shift;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       CLR;
  logic       ROT;
  logic       input_valid;
  logic [7:0] input_data;
  logic [1:0] tap_sel;

  logic       output_valid;
  logic [7:0] output_data;
  logic [7:0] tap_data;
  logic [2:0] fill_count;
  logic       full;

  logic       ov3;
  logic [7:0] od3;
  logic [7:0] td3;
  logic [1:0] fc3;
  logic       full3;

  int n_cmp;
  int n_bad;

  logic [7:0] sb [$];

  dff_link_n_shift #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .EN           (EN),
    .CLR          (CLR),
    .ROT          (ROT),
    .input_valid  (input_valid),
    .input_data   (input_data),
    .tap_sel      (tap_sel),
    .output_valid (output_valid),
    .output_data  (output_data),
    .tap_data     (tap_data),
    .fill_count   (fill_count),
    .full         (full)
  );

  dff_link_n_shift #(.WIDTH(8), .DEPTH(3)) dut3 (
    .CLK          (CLK),
    .RST          (RST),
    .EN           (EN),
    .CLR          (CLR),
    .ROT          (ROT),
    .input_valid  (input_valid),
    .input_data   (input_data),
    .tap_sel      (tap_sel),
    .output_valid (ov3),
    .output_data  (od3),
    .tap_data     (td3),
    .fill_count   (fc3),
    .full         (full3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one edge; the scoreboard records every valid word entering by a
  // linear shift and is emptied by a flush or reset.
  task automatic drive_edge(input logic rst, input logic clr, input logic en,
                            input logic rot, input logic v, input logic [7:0] d);
    RST = rst; CLR = clr; EN = en; ROT = rot; input_valid = v; input_data = d;
    if (rst || clr) sb.delete();
    else if (en && !rot && v) sb.push_back(d);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    drive_edge(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
    drive_edge(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
    n_cmp++; if (output_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", output_data); end
    n_cmp++; if (output_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", output_valid); end
    n_cmp++; if (fill_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fill_count); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if ({ov3, od3, fc3, full3} !== 12'h000) begin n_bad++; $display("FAIL reset_d3: got %b %h %0d %b want all 0", ov3, od3, fc3, full3); end
    drive_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_fill();
    logic [7:0] w      [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [2:0] cnt_up [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [2:0] cnt_dn [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    logic [7:0] exp_w;
    for (int i = 0; i < 5; i++) begin
      drive_edge(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, w[i]);
      n_cmp++; if (fill_count !== cnt_up[i]) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, fill_count, cnt_up[i]); end
      n_cmp++; if (full !== (i >= 3)) begin n_bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i >= 3)); end
      n_cmp++; if (output_valid !== (i >= 3)) begin n_bad++; $display("FAIL fill_latency[%0d]: valid got %b want %b", i, output_valid, (i >= 3)); end
      if (output_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL fill_data[%0d]: got %h, none expected", i, output_data); end
        else begin
          exp_w = sb.pop_front();
          if (output_data !== exp_w) begin n_bad++; $display("FAIL fill_data[%0d]: got %h want %h", i, output_data, exp_w); end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_cmp++; if (fill_count !== cnt_dn[i]) begin n_bad++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, fill_count, cnt_dn[i]); end
      n_cmp++; if (output_valid !== (i < 3)) begin n_bad++; $display("FAIL drain_valid[%0d]: got %b want %b", i, output_valid, (i < 3)); end
      if (output_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL drain_data[%0d]: got %h, none expected", i, output_data); end
        else begin
          exp_w = sb.pop_front();
          if (output_data !== exp_w) begin n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, output_data, exp_w); end
        end
      end
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL fill_leftover: got %0d words unseen want 0", sb.size()); end
  endtask

  task automatic test_hold();
    logic [7:0] w   [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       v   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] cnt [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic [7:0] exp_w;
    tap_sel = 2'd0;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) begin
        for (int h = 0; h < 3; h++) begin
          drive_edge(1'b0, 1'b0, 1'b0, h[0], 1'b1, 8'hEE);
          n_cmp++; if (fill_count !== 3'd2) begin n_bad++; $display("FAIL hold_count[%0d]: got %0d want 2", h, fill_count); end
          n_cmp++; if (tap_data !== 8'h22) begin n_bad++; $display("FAIL hold_tap[%0d]: got %h want 22", h, tap_data); end
          n_cmp++; if (output_valid !== 1'b0) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b want 0", h, output_valid); end
        end
      end
      drive_edge(1'b0, 1'b0, 1'b1, 1'b0, v[i], w[i]);
      n_cmp++; if (fill_count !== cnt[i]) begin n_bad++; $display("FAIL resume_count[%0d]: got %0d want %0d", i, fill_count, cnt[i]); end
      if (output_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL resume_data[%0d]: got %h, none expected", i, output_data); end
        else begin
          exp_w = sb.pop_front();
          if (output_data !== exp_w) begin n_bad++; $display("FAIL resume_data[%0d]: got %h want %h", i, output_data, exp_w); end
        end
      end
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL hold_leftover: got %0d words unseen want 0", sb.size()); end
  endtask

  task automatic test_rotate();
    logic [7:0] w     [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] rot_o [4] = '{8'h22, 8'h33, 8'h44, 8'h11};
    logic [2:0] cnt   [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    logic [7:0] exp_w;
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, w[i]);
      if (output_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL rot_fill_data[%0d]: got %h, none expected", i, output_data); end
        else begin
          exp_w = sb.pop_front();
          if (output_data !== exp_w) begin n_bad++; $display("FAIL rot_fill_data[%0d]: got %h want %h", i, output_data, exp_w); end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA);
      n_cmp++; if (output_data !== rot_o[i]) begin n_bad++; $display("FAIL rot_data[%0d]: got %h want %h", i, output_data, rot_o[i]); end
      n_cmp++; if (fill_count !== 3'd4) begin n_bad++; $display("FAIL rot_count[%0d]: got %0d want 4", i, fill_count); end
      n_cmp++; if (output_valid !== 1'b1) begin n_bad++; $display("FAIL rot_valid[%0d]: got %b want 1", i, output_valid); end
    end
    // A full rotation restores the original order, so the remaining words
    // drain exactly as the scoreboard expects.
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_cmp++; if (fill_count !== cnt[i]) begin n_bad++; $display("FAIL rot_drain_count[%0d]: got %0d want %0d", i, fill_count, cnt[i]); end
      if (output_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL rot_drain_data[%0d]: got %h, none expected", i, output_data); end
        else begin
          exp_w = sb.pop_front();
          if (output_data !== exp_w) begin n_bad++; $display("FAIL rot_drain_data[%0d]: got %h want %h", i, output_data, exp_w); end
        end
      end
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rot_leftover: got %0d words unseen want 0", sb.size()); end
  endtask

  task automatic test_clr_rst();
    logic [7:0] w [3] = '{8'h11, 8'h22, 8'h33};
    tap_sel = 2'd0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        drive_edge(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, w[i]);
      end
      n_cmp++; if (fill_count !== 3'd3) begin n_bad++; $display("FAIL flush_pre_count[%0d]: got %0d want 3", r, fill_count); end
      drive_edge(r[0], ~r[0], 1'b1, 1'b0, 1'b1, 8'h99);
      n_cmp++; if (fill_count !== 3'd0) begin n_bad++; $display("FAIL flush_count[%0d]: got %0d want 0", r, fill_count); end
      n_cmp++; if (output_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid[%0d]: got %b want 0", r, output_valid); end
      n_cmp++; if (output_data !== 8'h00) begin n_bad++; $display("FAIL flush_data[%0d]: got %h want 00", r, output_data); end
      n_cmp++; if (tap_data !== 8'h00) begin n_bad++; $display("FAIL flush_tap[%0d]: got %h want 00", r, tap_data); end
      n_cmp++; if ({ov3, fc3} !== 3'b000) begin n_bad++; $display("FAIL flush_d3[%0d]: got %b %0d want 0 0", r, ov3, fc3); end
    end
    drive_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_tap();
    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp_w;
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, w[i]);
      if (output_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL tap_fill_data[%0d]: got %h, none expected", i, output_data); end
        else begin
          exp_w = sb.pop_front();
          if (output_data !== exp_w) begin n_bad++; $display("FAIL tap_fill_data[%0d]: got %h want %h", i, output_data, exp_w); end
        end
      end
    end
    drive_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tap_sel = 2'd2; #1;
    n_cmp++; if (tap_data !== 8'h22) begin n_bad++; $display("FAIL tap2_d4: got %h want 22", tap_data); end
    n_cmp++; if (td3 !== 8'h22) begin n_bad++; $display("FAIL tap2_d3: got %h want 22", td3); end
    tap_sel = 2'd3; #1;
    n_cmp++; if (tap_data !== 8'h11) begin n_bad++; $display("FAIL tap3_d4: got %h want 11", tap_data); end
    n_cmp++; if (td3 !== 8'h00) begin n_bad++; $display("FAIL tap3_d3_oob: got %h want 00", td3); end
    tap_sel = 2'd0; #1;
    n_cmp++; if (tap_data !== 8'h44) begin n_bad++; $display("FAIL tap0_d4: got %h want 44", tap_data); end
    n_cmp++; if (td3 !== 8'h44) begin n_bad++; $display("FAIL tap0_d3: got %h want 44", td3); end
    drive_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 1'b0; EN = 1'b0; CLR = 1'b0; ROT = 1'b0;
    input_valid = 1'b0; input_data = 8'h00; tap_sel = 2'd0;
    test_reset();
    test_fill();
    test_hold();
    test_rotate();
    test_clr_rst();
    test_tap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dff_link_n_shift.md
Name: dff_link_n_shift

Overview:
- Parametrised successor to the fixed 4-stage DFF link: a WIDTH-bit, DEPTH-stage shift chain with a valid bit carried per stage.
- Adds shift enable, synchronous flush, rotate mode, a selectable tap output and an occupancy count.
- Used as a configurable delay line and alignment buffer between datapath blocks.

Parameters:
- WIDTH, 1, data bits per stage.
- DEPTH, 4, number of stages; must be at least 1.
- TAP_W, derived localparam, clog2(DEPTH), minimum 1; width of tap_sel.
- CNT_W, derived localparam, clog2(DEPTH+1); width of fill_count.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  shift enable; when low the chain holds.
- CLR  in  1  synchronous flush.
- ROT  in  1  0 = linear shift, 1 = rotate (last stage feeds stage 0).
- input_valid  in  1  qualifies input_data.
- input_data  in  WIDTH  data into stage 0.
- tap_sel  in  TAP_W  stage index for tap_data.
- output_valid  out  1  valid bit of stage DEPTH-1.
- output_data  out  WIDTH  data of stage DEPTH-1.
- tap_data  out  WIDTH  data of stage[tap_sel] (combinational mux).
- fill_count  out  CNT_W  number of stages whose valid bit is set.
- full  out  1  high when fill_count == DEPTH.

Behaviour:
- Priority per edge: RST > CLR > EN > hold.
- RST or CLR: every stage's data and valid bit go to 0, fill_count goes to 0. All outputs read 0 on the following cycle. This applies identically mid-stream.
- EN=1, ROT=0 (linear shift):
  - stage[0] <= {input_valid, input_data}.
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1.
  - stage[DEPTH-1] is discarded.
  - Data is not gated by input_valid; the valid bit travels with the data.
- EN=1, ROT=1 (rotate):
  - stage[0] <= stage[DEPTH-1]; the other stages shift as in linear mode.
  - input_data and input_valid are ignored.
  - fill_count is unchanged.
- EN=0: all stages hold; ROT, input_valid and input_data are ignored.
- Latency: with EN held high, a word presented before edge k is visible on output_data after edge k+DEPTH-1, i.e. DEPTH edges including the capture edge. DEPTH=1 gives 1-edge latency.
- output_data and output_valid are taken directly from the stage[DEPTH-1] register, with no extra flop.
- fill_count, registered:
  - linear shift: next = count + input_valid - stage[DEPTH-1].valid.
  - rotate or hold: count unchanged.
  - It never exceeds DEPTH and never underflows, by construction.
- full is combinational from fill_count.
- tap_data = stage[tap_sel].data. When tap_sel >= DEPTH (only possible for non-power-of-two DEPTH), tap_data = 0.
- Switching ROT between edges is legal; each edge obeys the ROT value sampled at that edge.

Decomposition:
- Shared package dff_link_pkg:
  - clog2 constant function.
  - Derived-width helpers for TAP_W and CNT_W.
  - Reset-value constant (all zeros).
- One natural sub-module, dff_link_stage: a single WIDTH+1-bit register with EN and CLR/RST handling, instantiated DEPTH times by a generate loop.
- Top level owns the rotate mux, tap mux and fill counter.

Test Plan:
- Reset: WIDTH=8, DEPTH=4; RST=1 for 2 edges with EN=1 and input 0xFF -> output_data=0, output_valid=0, fill_count=0, full=0.
- Fill/latency: EN=1, valid inputs 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive edges -> fill_count 1, 2, 3, 4, 4; full after edge 4; output_data 0x11 after edge 4, 0x22 after edge 5.
- Hold: after edge 2 of the fill scenario, drop EN for 3 cycles -> all outputs frozen; resume -> same sequence, delayed by 3 cycles.
- Rotate: start full with stage0..3 = 0x44, 0x33, 0x22, 0x11; ROT=1, EN=1 for 4 edges -> output_data 0x22, 0x33, 0x44, 0x11; fill_count stays 4; input_data ignored.
- CLR/RST mid-stream: CLR=1 together with EN=1 and input_valid=1 while fill_count=3 -> next cycle fill_count=0, output_valid=0, output_data=0. Repeat with RST=1 -> identical result.
- Tap: DEPTH=4, full with 0x44..0x11, tap_sel=2 -> tap_data=0x22. DEPTH=3, tap_sel=3 -> tap_data=0.
